// File: rtl/aes_sched_pkg.sv
// -----------------------------------------------------------------------------
// aes_sched_pkg
// Shared definitions for the AES request scheduler:
//   state_e      : scheduler FSM states (IDLE, LOAD, BUSY, RESP)
//   AES_BLK_W    : AES block / key width in bits
//   AES_CORE_LAT : cycles from the core load pulse to its done pulse
// -----------------------------------------------------------------------------
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int AES_BLK_W    = 128;
  localparam int AES_CORE_LAT = 12;

endpackage

// File: rtl/aes_rr_arb.sv
// -----------------------------------------------------------------------------
// aes_rr_arb
// Combinational round-robin picker. Grants the first asserted request found
// by searching upward from ptr, wrapping from NREQ-1 back to 0.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  IDW   index searched first
//   gnt     out NREQ  one-hot grant (zero when no request)
//   gnt_idx out IDW   index of the granted request (0 when no request)
// -----------------------------------------------------------------------------
module aes_rr_arb
  import aes_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    found   = 1'b0;
    idx     = '0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/aes_req_sched.sv
// -----------------------------------------------------------------------------
// aes_req_sched
// Round-robin scheduler sharing one AES-128 core between NREQ requesters.
// One job in flight at a time: grant -> one-cycle load pulse -> wait for the
// core's done pulse -> hold the tagged response until it is accepted.
//
// Optional feature: define AES_REQ_SCHED_WDOG_EN to add a watchdog that
// returns rsp_err=1 / rsp_data=0 if the core has not finished TIMEOUT cycles
// after the load pulse. Without it BUSY waits forever and rsp_err is 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester job handshake (ready one-hot/zero)
//   req_key/req_text         packed 128-bit key/plaintext per requester
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_data/rsp_err  owner id, ciphertext, watchdog error
//   core_ld/core_key/core_text_in   drive the cipher core
//   core_done/core_text_out         cipher core result
//   busy                     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module aes_req_sched
  import aes_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*AES_BLK_W-1:0] req_key,
  input  logic [NREQ*AES_BLK_W-1:0] req_text,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [AES_BLK_W-1:0]      rsp_data,
  output logic                      rsp_err,
  output logic                      core_ld,
  output logic [AES_BLK_W-1:0]      core_key,
  output logic [AES_BLK_W-1:0]      core_text_in,
  input  logic                      core_done,
  input  logic [AES_BLK_W-1:0]      core_text_out,
  output logic                      busy
);

  if (NREQ < 2 || NREQ > 16 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_param_chk
    $error("aes_req_sched: illegal parameter combination");
  end

  state_e                 state_q;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                   core_ld_q, busy_q, rsp_valid_q;
  logic [AES_BLK_W-1:0]   key_q, text_q, rsp_data_q;
  logic [IDW-1:0]         rsp_id_q;
  logic [NREQ-1:0]        gnt;
  logic [IDW-1:0]         gnt_idx;
  logic [AES_BLK_W-1:0]   key_slot  [NREQ];
  logic [AES_BLK_W-1:0]   text_slot [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign key_slot[i]  = req_key[AES_BLK_W*i +: AES_BLK_W];
    assign text_slot[i] = req_text[AES_BLK_W*i +: AES_BLK_W];
  end

  aes_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The winner of this grant is searched last next time.
  assign rr_ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Ready is the arbiter's pick, offered only while idle, so any valid in
  // IDLE completes a handshake in the same cycle.
  assign req_ready = (state_q == IDLE) ? gnt : '0;

`ifdef AES_REQ_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              rsp_err_q;

  assign wdog_d  = wdog_q + WDOG_W'(1);
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      core_ld_q   <= 1'b0;
      key_q       <= '0;
      text_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef AES_REQ_SCHED_WDOG_EN
      wdog_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            key_q     <= key_slot[gnt_idx];
            text_q    <= text_slot[gnt_idx];
            rsp_id_q  <= gnt_idx;
            rr_ptr_q  <= rr_ptr_d;
            core_ld_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          core_ld_q <= 1'b0;
          state_q   <= BUSY;
`ifdef AES_REQ_SCHED_WDOG_EN
          wdog_q    <= '0;
`endif
        end
        BUSY: begin
          if (core_done) begin
            rsp_data_q  <= core_text_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
`ifdef AES_REQ_SCHED_WDOG_EN
            rsp_err_q   <= 1'b0;
          end else if (wdog_d == WDOG_W'(TIMEOUT)) begin
            // Core never answered: report an error; rsp_id keeps the owner.
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            wdog_q      <= wdog_d;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_ld      = core_ld_q;
  assign core_key     = key_q;
  assign core_text_in = text_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_aes_req_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_req_sched
// Self-checking bench for aes_req_sched with a behavioural cipher-core stand-in
// (fixed latency, FIPS-197 answer for the FIPS operands, a simple keyed mix
// otherwise) and a round-robin reference model for grants and responses.
// -----------------------------------------------------------------------------
module tb_aes_req_sched;
  import aes_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_T = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_key, req_text;
  logic                 rsp_valid, rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [127:0]         rsp_data;
  logic                 rsp_err;
  logic                 core_ld;
  logic [127:0]         core_key, core_text_in;
  logic                 core_done;
  logic [127:0]         core_text_out;
  logic                 busy;

  logic [127:0] keys  [NREQ];
  logic [127:0] texts [NREQ];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  assign req_key  = {keys[3], keys[2], keys[1], keys[0]};
  assign req_text = {texts[3], texts[2], texts[1], texts[0]};

  aes_req_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_key       (req_key),
    .req_text      (req_text),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .core_ld       (core_ld),
    .core_key      (core_key),
    .core_text_in  (core_text_in),
    .core_done     (core_done),
    .core_text_out (core_text_out),
    .busy          (busy)
  );

  function automatic logic [127:0] fake_enc(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_K && t == FIPS_T) return FIPS_C;
    return {t[63:0], t[127:64]} ^ k ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Cipher-core stand-in: done arrives AES_CORE_LAT cycles after the load.
  logic [AES_CORE_LAT-1:0] pipe = '0;
  logic                    kill = 1'b0;
  logic [127:0]            mk = '0, mt = '0;

  always @(posedge clk) begin
    pipe <= {pipe[AES_CORE_LAT-2:0], core_ld};
    cyc  <= cyc + 1;
    if (core_ld) begin
      mk <= core_key;
      mt <= core_text_in;
    end
  end

  assign core_done     = pipe[AES_CORE_LAT-1] & ~kill;
  assign core_text_out = fake_enc(mk, mt);

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d required < 80000", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || core_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rsp_valid=%b busy=%b core_ld=%b required 0 0 0", rsp_valid, busy, core_ld);
    end
    n_tests++;
    if (core_key !== 128'd0 || core_text_in !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_core_ops: key=%h text=%h required 0", core_key, core_text_in);
    end
    n_tests++;
    if (rsp_id !== 2'd0 || rsp_data !== 128'd0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: id=%0d data=%h err=%b required 0", rsp_id, rsp_data, rsp_err);
    end
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready=%b required 0000", req_ready);
    end
    rst = 1'b0;
    tick();
    m_ptr = 0;
  endtask

  task automatic test_fips();
    int lat = 1;
    int ld_cnt = 1;
    keys[1] = FIPS_K;
    texts[1] = FIPS_T;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL fips_grant: req_ready=%b required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    n_tests++;
    if (core_ld !== 1'b1 || core_key !== FIPS_K || core_text_in !== FIPS_T) begin
      n_fail++;
      $display("FAIL fips_load: core_ld=%b key=%h text=%h required 1 %h %h", core_ld, core_key, core_text_in, FIPS_K, FIPS_T);
    end
    while (rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (core_ld === 1'b1) ld_cnt++;
    end
    n_tests++;
    if (lat != 14) begin
      n_fail++;
      $display("FAIL fips_latency: accept-to-rsp_valid=%0d required 14", lat);
    end
    n_tests++;
    if (ld_cnt != 1) begin
      n_fail++;
      $display("FAIL fips_ld_width: core_ld cycles=%0d required 1", ld_cnt);
    end
    n_tests++;
    if (rsp_data !== FIPS_C || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_rsp: data=%h id=%0d err=%b required %h 1 0", rsp_data, rsp_id, rsp_err, FIPS_C);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_release: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    m_ptr = 2;
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    int o;
    int lat;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < NREQ; k++) begin
      keys[k]  = rnd128();
      texts[k] = rnd128();
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      o = order[j];
      #1;
      n_tests++;
      if (req_ready !== 4'(1 << o)) begin
        n_fail++;
        $display("FAIL fair_grant%0d: req_ready=%b required %b", j, req_ready, 4'(1 << o));
      end
      tick();
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 30) begin
        tick();
        lat++;
      end
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(o) || rsp_data !== fake_enc(keys[o], texts[o])) begin
        n_fail++;
        $display("FAIL fair_rsp%0d: valid=%b id=%0d data=%h required 1 %0d %h", j, rsp_valid, rsp_id, rsp_data, o, fake_enc(keys[o], texts[o]));
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    m_ptr = 1;
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_d;
    int lat = 1;
    keys[2]  = rnd128();
    texts[2] = rnd128();
    exp_d = fake_enc(keys[2], texts[2]);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_grant: req_ready=%b required 0100", req_ready);
    end
    tick();
    req_valid = '0;
    while (rsp_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    req_valid = 4'hF;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 2'd2 || req_ready !== 4'b0000 || core_ld !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%h id=%0d ready=%b ld=%b required 1 %h 2 0000 0", c, rsp_valid, rsp_data, rsp_id, req_ready, core_ld, exp_d);
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    m_ptr = 3;
  endtask

  task automatic test_reset_mid_busy();
    int bad = 0;
    keys[3]  = rnd128();
    texts[3] = rnd128();
    req_valid = 4'b1000;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL rmb_grant: req_ready=%b required 1000", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (5) tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmb_busy_before: busy=%b required 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || core_ld !== 1'b0 || core_key !== 128'd0 || core_text_in !== 128'd0 ||
        rsp_id !== 2'd0 || rsp_data !== 128'd0 || rsp_err !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmb_reset_vals: valid=%b busy=%b ld=%b id=%0d data=%h err=%b ready=%b required all 0",
               rsp_valid, busy, core_ld, rsp_id, rsp_data, rsp_err, req_ready);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rmb_stray_done: cycles with rsp_valid/busy set=%0d required 0", bad);
    end
    m_ptr = 0;
  endtask

  task automatic test_random();
    int jobs = 0;
    int cycles = 0;
    int g;
    int exp_id = 0;
    int acc = 0;
    logic inflight = 1'b0;
    logic seen = 1'b0;
    logic [127:0] exp_d = '0;
    while (jobs < 40 && cycles < 4000) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NREQ; k++) begin
        keys[k]  = rnd128();
        texts[k] = rnd128();
      end
      #1;
      g = inflight ? -1 : exp_grant(req_valid, m_ptr);
      n_tests++;
      if (req_ready !== ((g < 0) ? 4'b0000 : 4'(1 << g))) begin
        n_fail++;
        $display("FAIL rnd_ready: cyc=%0d req_valid=%b req_ready=%b required %b", cyc, req_valid, req_ready,
                 (g < 0) ? 4'b0000 : 4'(1 << g));
      end
      if (g >= 0) begin
        inflight = 1'b1;
        seen     = 1'b0;
        exp_id   = g;
        exp_d    = fake_enc(keys[g], texts[g]);
        acc      = cyc;
        m_ptr    = (g + 1) % NREQ;
      end
      if (rsp_valid === 1'b1) begin
        n_tests++;
        if (!inflight) begin
          n_fail++;
          $display("FAIL rnd_spurious: rsp_valid=1 at cyc=%0d with no job outstanding, required 0", cyc);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            n_tests++;
            if (cyc - acc != 14) begin
              n_fail++;
              $display("FAIL rnd_latency: latency=%0d required 14", cyc - acc);
            end
          end
          if (rsp_ready) begin
            n_tests++;
            if (rsp_id !== 2'(exp_id) || rsp_data !== exp_d || rsp_err !== 1'b0) begin
              n_fail++;
              $display("FAIL rnd_rsp: id=%0d data=%h err=%b required %0d %h 0", rsp_id, rsp_data, rsp_err, exp_id, exp_d);
            end
            inflight = 1'b0;
            jobs++;
          end
        end
      end
      tick();
      cycles++;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    n_tests++;
    if (jobs != 40) begin
      n_fail++;
      $display("FAIL rnd_progress: jobs completed=%0d required 40", jobs);
    end
  endtask

`ifdef AES_REQ_SCHED_WDOG_EN
  task automatic test_watchdog();
    int g = m_ptr;
    int lat = 1;
    kill = 1'b1;
    keys[g]  = rnd128();
    texts[g] = rnd128();
    req_valid = 4'(1 << g);
    #1;
    n_tests++;
    if (req_ready !== 4'(1 << g)) begin
      n_fail++;
      $display("FAIL wd_grant: req_ready=%b required %b", req_ready, 4'(1 << g));
    end
    tick();
    req_valid = '0;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 34) begin
      n_fail++;
      $display("FAIL wd_latency: accept-to-rsp_valid=%0d required 34", lat);
    end
    n_tests++;
    if (rsp_err !== 1'b1 || rsp_data !== 128'd0 || rsp_id !== 2'(g)) begin
      n_fail++;
      $display("FAIL wd_rsp: err=%b data=%h id=%0d required 1 0 %0d", rsp_err, rsp_data, rsp_id, g);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    kill = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_release: busy=%b required 0", busy);
    end
    m_ptr = (g + 1) % NREQ;
  endtask
`else
  task automatic test_watchdog();
    int g = m_ptr;
    kill = 1'b1;
    req_valid = 4'(1 << g);
    #1;
    tick();
    req_valid = '0;
    repeat (60) tick();
    n_tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nowd_stuck: busy=%b rsp_valid=%b required 1 0", busy, rsp_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    kill = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nowd_recover: busy=%b required 0", busy);
    end
    m_ptr = 0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      keys[k]  = '0;
      texts[k] = '0;
    end
    test_reset();
    test_fips();
    test_fairness();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_req_sched.md
Name: aes_req_sched

Overview:
- Round-robin scheduler that shares one AES-128 cipher core between NREQ requesters.
- Accepts a key/plaintext job per requester over a valid/ready handshake and sequences the core: one-cycle load pulse, then waits for done.
- Returns the ciphertext tagged with the requester id over a valid/ready response channel.
- Sits between client blocks and the cipher core; it is the only driver of the core's load/key/text inputs.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, response id width, equal to clog2(NREQ).
- TIMEOUT, 32, watchdog limit in cycles from load pulse to core done (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_key  in  NREQ*128  keys; requester i uses bits [128*i+127:128*i].
- req_text  in  NREQ*128  plaintexts, same packing as req_key.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  128  ciphertext.
- rsp_err  out  1  watchdog error flag (0 when feature absent).
- core_ld  out  1  load pulse to cipher core.
- core_key  out  128  key to core.
- core_text_in  out  128  plaintext to core.
- core_done  in  1  core completion pulse.
- core_text_out  in  128  core ciphertext, valid when core_done=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, LOAD, BUSY, RESP.
- Reset: state=IDLE, rr_ptr=0, core_ld=0, core_key=0, core_text_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0. Reset mid-operation abandons the job with no response. A later core_done is ignored.
- IDLE: if any req_valid, grant the first set bit searching from rr_ptr upward with wrap at NREQ-1 to 0.
  - req_ready[g] is asserted combinationally in the same cycle. req_ready is 0 in all other states.
  - On the handshake, register core_key/core_text_in from slot g, register rsp_id=g, set rr_ptr=(g+1) mod NREQ, go to LOAD.
- LOAD: core_ld=1 for exactly one cycle, then BUSY. core_key/core_text_in stay stable from LOAD until the next grant.
- BUSY: wait for core_done=1. Capture core_text_out into rsp_data and set rsp_err=0, then go to RESP.
  - The core asserts done 12 cycles after core_ld, so accept-to-rsp_valid latency is 14 cycles.
- RESP: rsp_valid=1, with rsp_data/rsp_id/rsp_err held stable until rsp_ready=1. On the handshake, go to IDLE. The earliest next grant is the following cycle.
- core_done outside BUSY is ignored.
- Only one job is ever in flight; there is no queueing.
- A requester dropping req_valid before its grant is legal and loses nothing.

Optional Feature:
- Macro AES_REQ_SCHED_WDOG_EN.
- With the macro defined: a counter of width clog2(TIMEOUT+1) clears on LOAD and increments in BUSY. When it reaches TIMEOUT without core_done, go to RESP with rsp_err=1 and rsp_data=0. The job's rsp_id is preserved.
- Without the macro: no counter exists, BUSY waits indefinitely, and rsp_err is tied to 0.

Decomposition:
- Package aes_sched_pkg holds:
  - state enum {IDLE, LOAD, BUSY, RESP};
  - AES_BLK_W=128;
  - AES_CORE_LAT=12.
- Sub-module aes_rr_arb: a combinational round-robin picker. Inputs req[NREQ] and ptr[IDW]; outputs gnt one-hot and gnt_idx.
- The FSM, operand registers and watchdog live in aes_req_sched.

Test Plan:
- FIPS-197 vector: requester 1 sends key 000102030405060708090a0b0c0d0e0f and text 00112233445566778899aabbccddeeff.
  - Expect rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a and rsp_id=1.
  - Expect rsp_valid 14 cycles after accept, core_ld high exactly 1 cycle, rsp_err=0.
- Fairness: all 4 requesters hold req_valid with rsp_ready=1 tied.
  - Expect grant order 0,1,2,3,0 and each rsp_id matching its own ciphertext.
  - Expect no back-to-back regrant of the same id while others wait.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid.
  - Expect rsp_data/rsp_id stable, all req_ready=0, no extra core_ld.
  - Expect release on rsp_ready=1 and IDLE the next cycle.
- Reset mid-BUSY: rst=1 for 1 cycle at cycle 5 after core_ld.
  - Expect all outputs at reset values next cycle and no rsp_valid from the subsequent stray core_done.
- Watchdog, with AES_REQ_SCHED_WDOG_EN defined, TIMEOUT=32, core_done forced 0.
  - Expect rsp_valid with rsp_err=1 and rsp_data=0, 32 cycles after LOAD exit.
  - Without the macro, expect busy to remain 1.
